cordic_vector: RTL and testbench

Floating-point CORDIC in vectoring mode: the inverse of the team's rotation-mode sin/cos CORDIC. It takes an IEEE-754 single-precision vector (x, y) and iteratively rotates it onto the +x axis. It returns atan2(y, x) in radians and the vector magnitude sqrt(x² + y²), both float32. It sits beside the rotation core in the CORDIC processor, shares the same fpu add/sub/mul datapath style and the same 16-entry arctan(2^-i) constant table, and uses a start/busy/done handshake.

---
 rtl/cordic_vector.sv | 242 ++++++++++++++++++++++++
 tb/tb_cordic_vector.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vector.sv
// cordic_vector: float32 CORDIC in vectoring mode. Rotates (x, y) onto the +x axis
// and reports atan2(y, x) in radians plus the vector magnitude, both float32.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while idle
//   x_in/y_in  float32 vector, captured on the accepting edge
//   busy       high while preparing, iterating or scaling
//   done       one-cycle pulse; angle/magnitude valid from that cycle
//   angle      float32 atan2(y, x) in [-pi, +pi], held until the next done
//   magnitude  float32 vector length, held until the next done
//
// Build option: define CORDIC_VEC_GAIN_COMP_EN to multiply the final x by K = 0.6072529,
// cancelling the CORDIC gain. Without it the raw x (gain ~1.6467602) is reported.
// Arithmetic truncates; zeros and denormals are flushed to signed zero.
module cordic_vector #(
  parameter int unsigned ITER = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] angle,
  output logic [31:0] magnitude
);

  localparam logic [31:0] PosPi    = 32'h40490FDB;
  localparam logic [31:0] NegPi    = 32'hC0490FDB;
  localparam logic [3:0]  LastIter = 4'(ITER - 1);

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StScale, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] x_q, x_d, y_q, y_d, z_q, z_d, off_q, off_d;
  logic [31:0] angle_q, angle_d, mag_q, mag_d;
  logic        zero_q, zero_d;

  function automatic logic [31:0] fp_flush(input logic [31:0] a);
    return (a[30:23] == 8'd0) ? {a[31], 31'd0} : a;
  endfunction

  function automatic logic [31:0] fp_neg(input logic [31:0] a);
    return {~a[31], a[30:0]};
  endfunction

  // Multiply by 2^-i via the exponent; anything that would leave the normal range is +0.
  function automatic logic [31:0] fp_shr(input logic [31:0] a, input logic [3:0] i);
    if (a[30:23] <= {4'd0, i}) return 32'h0;
    return {a[31], a[30:23] - {4'd0, i}, a[22:0]};
  endfunction

  function automatic logic [31:0] atan_lut(input logic [3:0] i);
    logic [31:0] r;
    unique case (i)
      4'd0:  r = 32'h3F490FDB;
      4'd1:  r = 32'h3EED6338;
      4'd2:  r = 32'h3E7ADBB0;
      4'd3:  r = 32'h3DFEADD5;
      4'd4:  r = 32'h3D7FAADE;
      4'd5:  r = 32'h3CFFEAAE;
      4'd6:  r = 32'h3C7FFAAB;
      4'd7:  r = 32'h3BFFFEAB;
      4'd8:  r = 32'h3B7FFFAB;
      4'd9:  r = 32'h3AFFFFEB;
      4'd10: r = 32'h3A7FFFFB;
      4'd11: r = 32'h39FFFFFF;
      4'd12: r = 32'h39800000;
      4'd13: r = 32'h39000000;
      4'd14: r = 32'h38800000;
      default: r = 32'h38000000;
    endcase
    return r;
  endfunction

  // Truncating float32 add with three guard bits; underflow and exact cancellation give +0.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big, sml, r;
    logic [7:0]  dexp;
    logic [26:0] mb, ms;
    logic [27:0] sum;
    logic [8:0]  e, lz;
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    mb   = (big[30:23] == 8'd0) ? 27'd0 : {1'b1, big[22:0], 3'b000};
    ms   = (sml[30:23] == 8'd0) ? 27'd0 : {1'b1, sml[22:0], 3'b000};
    dexp = big[30:23] - sml[30:23];
    ms   = (dexp > 8'd26) ? 27'd0 : (ms >> dexp);
    sum  = (big[31] == sml[31]) ? ({1'b0, mb} + {1'b0, ms}) : ({1'b0, mb} - {1'b0, ms});
    e    = {1'b0, big[30:23]};
    lz   = 9'd0;
    // Highest set bit wins since the loop runs upward.
    for (int k = 0; k < 27; k++) begin
      if (sum[k]) lz = 9'(26 - k);
    end
    r = 32'h0;
    if (sum[27]) begin
      e = e + 9'd1;
      r = {big[31], e[7:0], sum[26:4]};
    end else if (sum != 28'd0 && e > lz) begin
      sum = sum << lz;
      e   = e - lz;
      r   = {big[31], e[7:0], sum[25:3]};
    end
    return r;
  endfunction

`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam logic [31:0] GainK = 32'h3F1B74EE;

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0]       p;
    logic signed [9:0] e;
    logic [22:0]       m;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      e = e + 10'sd1;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    if (e <= 10'sd0) return 32'h0;
    return {a[31] ^ b[31], e[7:0], m};
  endfunction
`endif

  logic        sigma_pos, x_neg;
  logic [31:0] xs, ys, at, x_b, y_b, z_b, x_nxt, y_nxt, z_nxt, ang_sum, mag_scaled;

  assign sigma_pos = y_q[31] && (y_q[30:23] != 8'd0);
  assign x_neg     = x_q[31] && (x_q[30:23] != 8'd0);
  assign xs        = fp_shr(x_q, cnt_q);
  assign ys        = fp_shr(y_q, cnt_q);
  assign at        = atan_lut(cnt_q);
  // sigma = +1 when y < 0: x -= ys, y += xs, z -= atan; otherwise the opposite signs.
  assign x_b       = sigma_pos ? fp_neg(ys) : ys;
  assign y_b       = sigma_pos ? xs : fp_neg(xs);
  assign z_b       = sigma_pos ? fp_neg(at) : at;
  assign x_nxt     = fp_add(x_q, x_b);
  assign y_nxt     = fp_add(y_q, y_b);
  assign z_nxt     = fp_add(z_q, z_b);
  assign ang_sum   = fp_add(z_q, off_q);
`ifdef CORDIC_VEC_GAIN_COMP_EN
  assign mag_scaled = fp_mul(x_q, GainK);
`else
  assign mag_scaled = x_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    off_d   = off_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          x_d     = fp_flush(x_in);
          y_d     = fp_flush(y_in);
          state_d = StPrep;
        end
      end
      StPrep: begin
        // Fold the left half-plane onto the right by a 180-degree turn.
        z_d    = 32'h0;
        cnt_d  = 4'd0;
        zero_d = (x_q[30:23] == 8'd0) && (y_q[30:23] == 8'd0);
        if (x_neg) begin
          x_d   = fp_neg(x_q);
          y_d   = fp_neg(y_q);
          off_d = (!y_q[31] || y_q[30:23] == 8'd0) ? PosPi : NegPi;
        end else begin
          off_d = 32'h0;
        end
        state_d = StIter;
      end
      StIter: begin
        x_d = x_nxt;
        y_d = y_nxt;
        z_d = z_nxt;
        if (cnt_q == LastIter) begin
          cnt_d   = 4'd0;
          state_d = StScale;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StScale: begin
        angle_d = zero_q ? 32'h0 : ang_sum;
        mag_d   = zero_q ? 32'h0 : mag_scaled;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      x_q     <= 32'h0;
      y_q     <= 32'h0;
      z_q     <= 32'h0;
      off_q   <= 32'h0;
      zero_q  <= 1'b0;
      angle_q <= 32'h0;
      mag_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      off_q   <= off_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
    end
  end

  assign busy      = (state_q == StPrep) || (state_q == StIter) || (state_q == StScale);
  assign done      = (state_q == StDone);
  assign angle     = angle_q;
  assign magnitude = mag_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Bench for cordic_vector: an ideal atan2/sqrt model with an acceptance/latency model,
// one per-cycle compare process, and literal expectations for selected vectors.
module tb_cordic_vector;
  localparam int unsigned ITER = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x_in = 32'h0;
  logic [31:0] y_in = 32'h0;
  logic        busy, done;
  logic [31:0] angle, magnitude;

  cordic_vector #(.ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .y_in(y_in),
    .busy(busy), .done(done), .angle(angle), .magnitude(magnitude)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  next_free = 0;
  int  last_acc = 0;
  real gain = 1.0;

  int  q_e[$];
  real q_ang[$];
  real q_mag[$];
  bit  q_zero[$];
  bit  q_lit[$];
  real q_la[$];
  real q_lm[$];

  bit  lit_pend = 1'b0;
  real lit_ang = 0.0;
  real lit_mag = 0.0;
  bit  held_exact = 1'b1;
  real held_ang = 0.0;
  real held_mag = 0.0;

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    m = m * (2.0 ** real'(e));
    return b[31] ? -m : m;
  endfunction

  task automatic chk_bit(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b want %b", name, cyc, act, expv);
    end
  endtask

  task automatic chk_bits(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, expv);
    end
  endtask

  task automatic chk_tol(input string name, input logic [31:0] act, input real expv,
                         input real tol, input bit rel);
    real diff, lim;
    checks++;
    diff = f2r(act) - expv;
    if (diff < 0.0) diff = -diff;
    lim = rel ? tol * ((expv < 0.0) ? -expv : expv) : tol;
    if (diff > lim || act[30:23] == 8'hFF) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h (%f) want %f", name, cyc, act, f2r(act), expv);
    end
  endtask

  // Acceptance model: start is taken on an edge where the block is idle, which is
  // ITER+4 edges after the previous acceptance or any edge after reset.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (rst_n && start && cyc >= next_free) begin
      real xr, yr;
      bit  z;
      xr = f2r(x_in);
      yr = f2r(y_in);
      z  = (x_in[30:23] == 8'd0) && (y_in[30:23] == 8'd0);
      q_e.push_back(cyc);
      q_zero.push_back(z);
      q_ang.push_back(z ? 0.0 : $atan2(yr, xr));
      q_mag.push_back(z ? 0.0 : $sqrt(xr * xr + yr * yr) * gain);
      q_lit.push_back(lit_pend);
      q_la.push_back(lit_ang);
      q_lm.push_back(lit_mag);
      lit_pend  = 1'b0;
      last_acc  = cyc;
      next_free = cyc + ITER + 4;
    end
  end

  // Compare process: every cycle, on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk_bit("reset_busy", busy, 1'b0);
      chk_bit("reset_done", done, 1'b0);
      chk_bits("reset_angle", angle, 32'h0);
      chk_bits("reset_mag", magnitude, 32'h0);
      held_exact = 1'b1;
    end else begin
      bit exp_busy, exp_done;
      exp_busy = (q_e.size() > 0) && (cyc >= q_e[0]) && (cyc <= q_e[0] + ITER + 1);
      exp_done = (q_e.size() > 0) && (cyc == q_e[0] + ITER + 2);
      chk_bit("busy", busy, exp_busy);
      chk_bit("done", done, exp_done);
      if (exp_done) begin
        if (q_zero[0]) begin
          chk_bits("angle_zero", angle, 32'h0);
          chk_bits("mag_zero", magnitude, 32'h0);
        end else begin
          chk_tol("angle", angle, q_ang[0], 4e-5, 1'b0);
          chk_tol("magnitude", magnitude, q_mag[0], 1e-4, 1'b1);
        end
        if (q_lit[0]) begin
          chk_tol("angle_literal", angle, q_la[0], 4e-5, 1'b0);
          chk_tol("mag_literal", magnitude, q_lm[0], 1e-4, 1'b1);
        end
        held_exact = q_zero[0];
        held_ang   = q_ang[0];
        held_mag   = q_mag[0];
        void'(q_e.pop_front());
        void'(q_zero.pop_front());
        void'(q_ang.pop_front());
        void'(q_mag.pop_front());
        void'(q_lit.pop_front());
        void'(q_la.pop_front());
        void'(q_lm.pop_front());
      end else if (held_exact) begin
        chk_bits("angle_hold", angle, 32'h0);
        chk_bits("mag_hold", magnitude, 32'h0);
      end else begin
        chk_tol("angle_hold", angle, held_ang, 4e-5, 1'b0);
        chk_tol("mag_hold", magnitude, held_mag, 1e-4, 1'b1);
      end
    end
  end

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input bit lit,
                        input real la, input real lm);
    @(negedge clk);
    x_in     = x;
    y_in     = y;
    start    = 1'b1;
    lit_pend = lit;
    lit_ang  = la;
    lit_mag  = lm;
    @(negedge clk);
    start = 1'b0;
    x_in  = $urandom();
    y_in  = $urandom();
    repeat (ITER + 4) @(negedge clk);
  endtask

  real g_lit;
  int  e0;

  initial begin
    for (int i = 0; i < int'(ITER); i++) gain = gain * $sqrt(1.0 + 2.0 ** real'(-2 * i));
`ifdef CORDIC_VEC_GAIN_COMP_EN
    gain  = gain * f2r(32'h3F1B74EE);
    g_lit = 1.0;
`else
    g_lit = 1.6467602;
`endif

    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    run_op(32'h3F800000, 32'h3F800000, 1'b1, 0.7853982, 1.4142136 * g_lit);  // (1, 1)
    run_op(32'hC0400000, 32'hC0800000, 1'b1, -2.2142975, 5.0 * g_lit);      // (-3, -4)
    run_op(32'hBF800000, 32'h00000000, 1'b1, 3.1415927, 1.0 * g_lit);       // (-1, +0)
    run_op(32'h00000000, 32'hC0000000, 1'b1, -1.5707964, 2.0 * g_lit);      // (0, -2)
    run_op(32'hBF800000, 32'h80000000, 1'b1, 3.1415927, 1.0 * g_lit);       // (-1, -0)
    run_op(32'h40400000, 32'hBF000000, 1'b0, 0.0, 0.0);                     // (3, -0.5)
    run_op(32'h00000000, 32'h80000000, 1'b0, 0.0, 0.0);                     // (+0, -0)
    run_op(32'h00000001, 32'h00000000, 1'b0, 0.0, 0.0);                     // denormal x

    // start re-pulsed while busy is ignored; then start in the cycle after done.
    @(negedge clk);
    x_in  = 32'h40000000;
    y_in  = 32'h3F000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0    = last_acc;
    while (cyc < e0 + 5) @(negedge clk);
    x_in  = 32'h40A00000;
    y_in  = 32'h40A00000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + int'(ITER) + 3) @(negedge clk);
    x_in  = 32'hC0400000;
    y_in  = 32'h40800000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (ITER + 4) @(negedge clk);

    // start held high: a new operation each time idle is re-entered.
    x_in  = 32'h40400000;
    y_in  = 32'h40800000;
    start = 1'b1;
    repeat (2 * (ITER + 4) + 1) @(negedge clk);
    start = 1'b0;
    repeat (ITER + 4) @(negedge clk);

    // Reset while iteration 7 is in flight.
    x_in  = 32'hC0400000;
    y_in  = 32'h40800000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0    = last_acc;
    while (cyc < e0 + 8) @(negedge clk);
    #2 rst_n = 1'b0;
    q_e.delete();
    q_zero.delete();
    q_ang.delete();
    q_mag.delete();
    q_lit.delete();
    q_la.delete();
    q_lm.delete();
    next_free = 0;
    #1;
    chk_bit("midop_reset_busy", busy, 1'b0);
    chk_bit("midop_reset_done", done, 1'b0);
    chk_bits("midop_reset_angle", angle, 32'h0);
    chk_bits("midop_reset_mag", magnitude, 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_op(32'hC0400000, 32'hC0800000, 1'b1, -2.2142975, 5.0 * g_lit);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
